// File: rtl/inst_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the op-class enum seen on the request port, 7-bit base opcodes (also used
// by the immediate generator), the instruction format enum, the canonical NOP word,
// the request struct fed to the word packer and an immediate range helper.
package inst_pkg;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_OPIMM  = 4'd7,
        OP_OP     = 4'd8,
        OP_LI     = 4'd9
    } op_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R
    } fmt_e;

    localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0,x0,0

    // shift=1 selects the shamt flavour of the I format (slli/srli/srai).
    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic        shift;
        logic [31:0] imm;
    } pack_req_t;

    // True when the two's-complement value v lies outside [lo, hi].
    function automatic logic out_of_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) < lo) || ($signed(v) > hi);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational instruction word packer.
// Scatters the immediate into the bit positions of the selected format and reports
// whether the immediate is representable (range and alignment) in that format.
// Ports:
//   req       in   pack_req_t  format, opcode, register/funct fields, byte immediate
//   word      out  32          assembled instruction word
//   range_err out  1           immediate not representable in this format
module inst_pack
    import inst_pkg::*;
(
    input  pack_req_t   req,
    output logic [31:0] word,
    output logic        range_err
);

    logic [31:0] imm;
    assign imm = req.imm;

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (req.fmt)
            FMT_I: begin
                if (req.shift) begin
                    word      = {1'b0, req.alt, 5'b0, imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
                    range_err = (imm > 32'd31);
                end else begin
                    word      = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                    range_err = out_of_range(imm, -2048, 2047);
                end
            end
            FMT_S: begin
                word      = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
                range_err = out_of_range(imm, -2048, 2047);
            end
            FMT_B: begin
                word      = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3, imm[4:1], imm[11], req.opcode};
                range_err = out_of_range(imm, -4096, 4094) || imm[0];
            end
            FMT_U: begin
                word      = {imm[31:12], req.rd, req.opcode};
                range_err = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
                range_err = out_of_range(imm, -1048576, 1048574) || imm[0];
            end
            FMT_R: begin
                word      = {1'b0, req.alt, 5'b0, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            end
            default: begin
                word      = '0;
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: turns decoded fields into instruction words for the
// instruction memory write port, and expands LI into LUI+ADDI when needed.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready          request handshake
//   in_op, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm   decoded request fields
//   out_valid/out_ready        word handshake (single registered output stage)
//   out_inst                   encoded word (ERR_INST on error)
//   out_err                    request was illegal or its immediate unrepresentable
//   out_last                   final word of the request (0 only on the LUI half of LI)
module inst_encoder
    import inst_pkg::*;
#(
    parameter bit          CHECK_RANGE = 1'b1,
    parameter logic [31:0] ERR_INST    = NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last
);

    typedef enum logic {IDLE, LI2} state_e;

    state_e      state, state_nx;
    pack_req_t   req;
    logic [31:0] word;
    logic        range_err;
    logic        op_bad, br_f3_bad, err;
    logic        accept, li_small, li_two, load_li2;
    logic [19:0] li_hi;
    logic [4:0]  li_rd;
    logic [11:0] li_lo;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // LI split: ADDI sign-extends lo, so hi is rounded up by 0x800 to compensate.
    assign li_small = !out_of_range(in_imm, -2048, 2047);
    assign li_hi    = 20'((in_imm + 32'h800) >> 12);
    assign li_two   = (in_op == OP_LI) && !li_small && (in_imm[11:0] != 12'd0);

    assign br_f3_bad = (in_op == OP_BRANCH) && (in_funct3[2:1] == 2'b01);

    // Packer input: the ADDI half while in LI2, otherwise the incoming request.
    always_comb begin
        req        = '0;
        req.rd     = in_rd;
        req.rs1    = in_rs1;
        req.rs2    = in_rs2;
        req.funct3 = in_funct3;
        req.imm    = in_imm;
        req.fmt    = FMT_I;
        op_bad     = 1'b0;
        if (state == LI2) begin
            req.opcode = OPCODE_OPIMM;
            req.rd     = li_rd;
            req.rs1    = li_rd;
            req.funct3 = 3'd0;
            req.imm    = {{20{li_lo[11]}}, li_lo};
        end else begin
            case (in_op)
                OP_LUI:    begin req.fmt = FMT_U; req.opcode = OPCODE_LUI;    end
                OP_AUIPC:  begin req.fmt = FMT_U; req.opcode = OPCODE_AUIPC;  end
                OP_JAL:    begin req.fmt = FMT_J; req.opcode = OPCODE_JAL;    end
                OP_JALR:   begin req.fmt = FMT_I; req.opcode = OPCODE_JALR;   end
                OP_BRANCH: begin req.fmt = FMT_B; req.opcode = OPCODE_BRANCH; end
                OP_LOAD:   begin req.fmt = FMT_I; req.opcode = OPCODE_LOAD;   end
                OP_STORE:  begin req.fmt = FMT_S; req.opcode = OPCODE_STORE;  end
                OP_OPIMM: begin
                    req.fmt    = FMT_I;
                    req.opcode = OPCODE_OPIMM;
                    req.shift  = (in_funct3[1:0] == 2'b01);
                    req.alt    = in_alt && (in_funct3 == 3'b101);
                end
                OP_OP: begin
                    req.fmt    = FMT_R;
                    req.opcode = OPCODE_OP;
                    req.alt    = in_alt;
                end
                OP_LI: begin
                    req.funct3 = 3'd0;
                    if (li_small) begin
                        req.opcode = OPCODE_OPIMM;
                        req.rs1    = 5'd0;
                    end else begin
                        req.fmt    = FMT_U;
                        req.opcode = OPCODE_LUI;
                        req.imm    = {li_hi, 12'd0};
                    end
                end
                default: op_bad = 1'b1;
            endcase
        end
    end

    inst_pack u_pack (
        .req       (req),
        .word      (word),
        .range_err (range_err)
    );

    assign err = op_bad || (CHECK_RANGE && (range_err || br_f3_bad));

    // out_valid is always 1 in LI2 (the LUI half is on the output), so
    // out_ready alone marks its handshake.
    assign load_li2 = (state == LI2) && out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && li_two) state_nx = LI2;
            LI2:     if (out_ready)        state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            li_rd     <= '0;
            li_lo     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                out_valid <= 1'b1;
                out_inst  <= err ? ERR_INST : word;
                out_err   <= err;
                out_last  <= err || !li_two;
                li_rd     <= in_rd;
                li_lo     <= in_imm[11:0];
            end else if (load_li2) begin
                out_valid <= 1'b1;
                out_inst  <= word;
                out_err   <= 1'b0;
                out_last  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    import inst_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [31:0] in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_inst;
    logic        out_err, out_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .out_last(out_last)
    );

    // Reference: returns number of words; each word is {err,last,inst}.
    function automatic int ref_encode(input logic [3:0] op, input logic [4:0] rd, rs1, rs2,
                                      input logic [2:0] f3, input logic alt, input logic [31:0] imm,
                                      output logic [33:0] e0, output logic [33:0] e1);
        longint s  = longint'($signed(imm));
        longint u  = longint'(imm);
        longint d  = longint'(rd);
        longint r1 = longint'(rs1);
        longint r2 = longint'(rs2);
        longint fn = longint'(f3);
        longint w  = 0;
        longint lo, hi;
        bit bad = 0;
        int n = 1;
        e1 = '0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                bad = (u % 4096) != 0;
                w = (u & 64'hFFFFF000) + (d << 7) + ((op == OP_LUI) ? 'h37 : 'h17);
            end
            OP_JAL: begin
                bad = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
                w = (((u >> 20) & 1) << 31) + (((u >> 1) & 1023) << 21) + (((u >> 11) & 1) << 20)
                  + (((u >> 12) & 255) << 12) + (d << 7) + 'h6F;
            end
            OP_BRANCH: begin
                bad = (f3 == 3'd2) || (f3 == 3'd3) || (s < -4096) || (s > 4094) || (s % 2 != 0);
                w = (((u >> 12) & 1) << 31) + (((u >> 5) & 63) << 25) + (r2 << 20) + (r1 << 15)
                  + (fn << 12) + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7) + 'h63;
            end
            OP_LOAD, OP_JALR, OP_OPIMM: begin
                if (op == OP_OPIMM && (f3 == 3'd1 || f3 == 3'd5)) begin
                    bad = u > 31;
                    w = ((alt && f3 == 3'd5) ? (64'd1 << 30) : 64'd0) + ((u & 31) << 20);
                end else begin
                    bad = (s < -2048) || (s > 2047);
                    w = (u & 4095) << 20;
                end
                w = w + (r1 << 15) + (fn << 12) + (d << 7)
                  + ((op == OP_LOAD) ? 'h03 : (op == OP_JALR) ? 'h67 : 'h13);
            end
            OP_STORE: begin
                bad = (s < -2048) || (s > 2047);
                w = (((u >> 5) & 127) << 25) + (r2 << 20) + (r1 << 15) + (fn << 12) + ((u & 31) << 7) + 'h23;
            end
            OP_OP: begin
                w = (alt ? (64'd1 << 30) : 64'd0) + (r2 << 20) + (r1 << 15) + (fn << 12) + (d << 7) + 'h33;
            end
            OP_LI: begin
                if (s >= -2048 && s <= 2047) begin
                    w = ((u & 4095) << 20) + (d << 7) + 'h13;
                end else begin
                    lo = ((u & 4095) >= 2048) ? (u & 4095) - 4096 : (u & 4095);
                    hi = ((s - lo) >>> 12) & 64'hFFFFF;
                    w  = (hi << 12) + (d << 7) + 'h37;
                    if (lo != 0) begin
                        n = 2;
                        e1 = {2'b01, 32'(((lo & 4095) << 20) + (d << 15) + (d << 7) + 'h13)};
                    end
                end
            end
            default: bad = 1;
        endcase
        if (bad)       e0 = {2'b11, 32'h13};
        else if (n==2) e0 = {2'b00, w[31:0]};
        else           e0 = {2'b01, w[31:0]};
        return bad ? 1 : n;
    endfunction

    // Drives one request with out_ready=1 and collects its words; lat0=1 if the
    // first word was visible one cycle after acceptance.
    task automatic do_req(input logic [3:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                          input logic alt, input logic [31:0] imm,
                          output logic [33:0] g0, output logic [33:0] g1, output int n, output bit lat0);
        int cyc = 0;
        bit done = 0;
        g0 = '0; g1 = '0; n = 0; lat0 = 0;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_alt = alt; in_imm = imm;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        while (!in_ready && cyc < 50) begin @(negedge clk); #1; cyc++; end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL req_timeout: in_ready stuck low, required high");
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat0 = out_valid;
        cyc = 0;
        while (!done && cyc < 20) begin
            if (out_valid) begin
                if (n == 0) g0 = {out_err, out_last, out_inst};
                else        g1 = {out_err, out_last, out_inst};
                n++;
                if (out_last || n == 2) done = 1;
            end
            if (!done) begin @(negedge clk); cyc++; end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({out_valid, out_inst, out_err, out_last} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b inst=%h err=%b last=%b, required all 0",
                     out_valid, out_inst, out_err, out_last);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    typedef struct {
        logic [3:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic alt; logic [31:0] imm;
        int n; logic [33:0] e0, e1;
    } vec_t;

    task automatic test_directed();
        vec_t v[14];
        logic [33:0] g0, g1;
        int n; bit lat0;
        v[0]  = '{OP_OPIMM,  2, 2, 0, 0, 0, 32'hFFFFFF80, 1, {2'b01, 32'hf8010113}, 34'd0};
        v[1]  = '{OP_LUI,    2, 0, 0, 0, 0, 32'h08030000, 1, {2'b01, 32'h08030137}, 34'd0};
        v[2]  = '{OP_STORE,  0, 2, 1, 2, 0, 32'd124,      1, {2'b01, 32'h06112e23}, 34'd0};
        v[3]  = '{OP_BRANCH, 0, 14, 15, 1, 0, 32'd20,     1, {2'b01, 32'h00f71a63}, 34'd0};
        v[4]  = '{OP_LI,     5, 0, 0, 0, 0, 32'h12345FFF, 2, {2'b00, 32'h123462B7}, {2'b01, 32'hFFF28293}};
        v[5]  = '{OP_JAL,    0, 0, 0, 0, 0, 32'h101,      1, {2'b11, 32'h00000013}, 34'd0};
        v[6]  = '{OP_BRANCH, 0, 1, 2, 0, 0, 32'd4096,     1, {2'b11, 32'h00000013}, 34'd0};
        v[7]  = '{OP_LI,     5, 0, 0, 0, 0, 32'hFFFFFFFF, 1, {2'b01, 32'hFFF00293}, 34'd0};
        v[8]  = '{OP_LI,     5, 0, 0, 0, 0, 32'h12345000, 1, {2'b01, 32'h123452B7}, 34'd0};
        v[9]  = '{OP_OPIMM,  1, 1, 0, 5, 1, 32'd3,        1, {2'b01, 32'h4030D093}, 34'd0};
        v[10] = '{OP_OPIMM,  1, 1, 0, 1, 0, 32'd32,       1, {2'b11, 32'h00000013}, 34'd0};
        v[11] = '{OP_OP,     3, 1, 2, 0, 1, 32'hDEADBEEF, 1, {2'b01, 32'h402081B3}, 34'd0};
        v[12] = '{4'd12,     3, 1, 2, 0, 0, 32'd0,        1, {2'b11, 32'h00000013}, 34'd0};
        v[13] = '{OP_JAL,    0, 0, 0, 0, 0, 32'h000FFFFE, 1, {2'b01, 32'h7FFFF06F}, 34'd0};
        for (int i = 0; i < 14; i++) begin
            do_req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].alt, v[i].imm, g0, g1, n, lat0);
            n_checks++;
            if (n !== v[i].n || g0 !== v[i].e0 || (n == 2 && g1 !== v[i].e1)) begin
                n_fail++;
                $display("FAIL directed[%0d]: got n=%0d w0=%h w1=%h, required n=%0d w0=%h w1=%h",
                         i, n, g0, g1, v[i].n, v[i].e0, v[i].e1);
            end
            n_checks++;
            if (lat0 !== 1'b1) begin
                n_fail++; $display("FAIL latency[%0d]: word not valid 1 cycle after accept", i);
            end
        end
        do_req(OP_JAL, 7, 0, 0, 0, 0, 32'hFFF00000, g0, g1, n, lat0);
        n_checks++;
        if (g0 !== {2'b01, 32'h800003EF}) begin
            n_fail++; $display("FAIL jal_min: got %h, required %h", g0, {2'b01, 32'h800003EF});
        end
    endtask

    task automatic test_li_stall();
        logic [31:0] held;
        @(negedge clk);
        in_op = OP_LI; in_rd = 5; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_alt = 0;
        in_imm = 32'h12345FFF; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        held = out_inst;
        n_checks++;
        if ({out_valid, out_last, out_inst} !== {2'b10, 32'h123462B7}) begin
            n_fail++; $display("FAIL stall_lui: got v=%b last=%b %h, required v=1 last=0 123462b7",
                               out_valid, out_last, out_inst);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            @(negedge clk); #1;
            n_checks++;
            if (out_inst !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h in_ready=%b, required v=1 %h in_ready=0",
                                   i, out_valid, out_inst, in_ready, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_last, out_inst} !== {2'b11, 32'hFFF28293}) begin
            n_fail++; $display("FAIL stall_addi: got v=%b last=%b %h, required v=1 last=1 fff28293",
                               out_valid, out_last, out_inst);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain: out_valid=%b, required 0", out_valid);
        end
        // Output backpressure in IDLE must also block new requests.
        out_ready = 1'b0;
        in_op = OP_OP; in_valid = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL backpressure: got v=%b in_ready=%b, required v=1 in_ready=0",
                               out_valid, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_li();
        bit seen = 0;
        @(negedge clk);
        in_op = OP_LI; in_rd = 9; in_imm = 32'h7FFFF801; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: out_valid=%b, required 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        n_checks++;
        if (seen || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_no_addi: word seen=%b in_ready=%b, required 0 and 1", seen, in_ready);
        end
    endtask

    task automatic test_random();
        logic [33:0] g0, g1, e0, e1;
        int n, en;
        bit lat0;
        logic [3:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic alt; logic [31:0] imm;
        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 15));
            rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            f3  = 3'($urandom); alt = 1'($urandom);
            case ($urandom_range(0, 5))
                0: imm = 32'($signed($urandom_range(0, 4200)) - 2100);
                1: imm = 32'(($signed($urandom_range(0, 4200)) - 2100) * 2);
                2: imm = $urandom;
                3: imm = $urandom & 32'hFFFFF000;
                4: imm = 32'($urandom_range(0, 40));
                default: imm = 32'(($signed($urandom_range(0, 32'h200000)) - 32'sh100000) * 2);
            endcase
            en = ref_encode(op, rd, rs1, rs2, f3, alt, imm, e0, e1);
            do_req(op, rd, rs1, rs2, f3, alt, imm, g0, g1, n, lat0);
            n_checks++;
            if (n !== en || g0 !== e0 || (en == 2 && g1 !== e1) || !lat0) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d alt=%b imm=%h: got n=%0d %h %h lat=%b, required n=%0d %h %h",
                         i, op, rd, rs1, rs2, f3, alt, imm, n, g0, g1, lat0, en, e0, e1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_alt = 1'b0; in_imm = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_li_stall();
        test_random();
        test_reset_mid_li();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
